// File: rtl/sw_debounce_evt.sv
// -----------------------------------------------------------------------------
// sw_debounce_evt
//   Conditions raw board switch/button pins for the control logic. Each pin is
//   synchronised into clk_125, debounced by a per-channel counter FSM, and
//   reported three ways: a clean level, one-cycle rise/fall pulses, and a
//   valid/ready event stream carrying the channel index and its new level.
//
// Ports
//   clk_125    in   1      rising-edge clock for all logic
//   rst_n      in   1      asynchronous assert, active-low reset
//   sw_raw     in   N_IN   raw asynchronous pin levels
//   sw_clean   out  N_IN   debounced level per channel
//   sw_rise    out  N_IN   one-cycle pulse on accepted 0->1 transition
//   sw_fall    out  N_IN   one-cycle pulse on accepted 1->0 transition
//   evt_valid  out  1      at least one event pending
//   evt_ready  in   1      consumer takes the presented event this cycle
//   evt_idx    out  IDX_W  lowest pending channel index
//   evt_level  out  1      new debounced level of that channel
//   evt_ovf    out  1      sticky: an event overwrote a still-pending one
//   ovf_clr    in   1      synchronous clear of evt_ovf (a new overflow wins)
// -----------------------------------------------------------------------------
module sw_debounce_evt #(
    parameter int N_IN            = 2,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1250000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES),
    localparam int IDX_W          = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic             clk_125,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  sw_raw,
    output logic [N_IN-1:0]  sw_clean,
    output logic [N_IN-1:0]  sw_rise,
    output logic [N_IN-1:0]  sw_fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_level,
    output logic             evt_ovf,
    input  logic             ovf_clr
);

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } st_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Accepted transitions, valid in the cycle before they are registered.
    logic [N_IN-1:0] acc_evt;
    logic [N_IN-1:0] acc_lvl;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            st_e                    state_q, state_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   clean_q, clean_d;
            logic                   rise_q, rise_d;
            logic                   fall_q, fall_d;
            logic                   s;

            assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw[gi]};
            assign s      = sync_q[SYNC_STAGES-1];

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                clean_d = clean_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                case (state_q)
                    ST_LO: begin
                        if (s) begin
                            state_d = WAIT_HI;
                            cnt_d   = '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state_d = ST_LO;              // bounce rejected
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_HI;
                            clean_d = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HI: begin
                        if (!s) begin
                            state_d = WAIT_LO;
                            cnt_d   = '0;
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state_d = ST_HI;              // bounce rejected
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_LO;
                            clean_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = ST_LO;
                endcase
            end

            always_ff @(posedge clk_125 or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q  <= '0;
                    state_q <= ST_LO;
                    cnt_q   <= '0;
                    clean_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    clean_q <= clean_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign sw_clean[gi] = clean_q;
            assign sw_rise[gi]  = rise_q;
            assign sw_fall[gi]  = fall_q;
            assign acc_evt[gi]  = rise_d | fall_d;
            assign acc_lvl[gi]  = rise_d;
        end
    endgenerate

    // ---------------------------------------------------------------- events
    logic [N_IN-1:0] pend_q, pend_d;
    logic [N_IN-1:0] lvl_q, lvl_d;
    logic            ovf_q, ovf_d;
    logic            pop;

    // Presented event: lowest pending index, scanned high to low so the
    // last hit wins. Outputs idle at zero when nothing is pending.
    always_comb begin
        evt_idx   = '0;
        evt_level = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                evt_idx   = IDX_W'(i);
                evt_level = lvl_q[i];
            end
        end
    end

    assign evt_valid = |pend_q;
    assign evt_ovf   = ovf_q;
    assign pop       = evt_valid & evt_ready;

    always_comb begin
        pend_d = pend_q;
        lvl_d  = lvl_q;
        ovf_d  = ovf_q & ~ovf_clr;
        for (int i = 0; i < N_IN; i++) begin
            logic pop_i;
            pop_i = pop && (evt_idx == IDX_W'(i));
            if (pop_i) begin
                pend_d[i] = 1'b0;
            end
            // A new transition re-arms the slot; it only counts as a loss
            // if the old event is still sitting there after this edge.
            if (acc_evt[i]) begin
                if (pend_q[i] && !pop_i) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                lvl_d[i]  = acc_lvl[i];
            end
        end
    end

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            lvl_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            lvl_q  <= lvl_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sw_debounce_evt.sv
module tb_sw_debounce_evt;

    logic       clk_125   = 1'b0;
    logic       rst_n     = 1'b0;
    logic [1:0] sw_raw    = 2'b00;
    logic       evt_ready = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic [1:0] sw_clean;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic       evt_valid;
    logic [0:0] evt_idx;
    logic       evt_level;
    logic       evt_ovf;

    always #5 clk_125 = ~clk_125;

    sw_debounce_evt #(
        .N_IN            (2),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_125   (clk_125),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_level (evt_level),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] raw;
        logic       rdy;
        logic       clr;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       valid;
        logic       idx;
        logic       lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] raw, input logic rdy, input logic clr,
                                input logic [1:0] clean, input logic [1:0] rise,
                                input logic [1:0] fall, input logic valid, input logic idx,
                                input logic lvl, input logic ovf);
        vec_t v;
        v.raw = raw; v.rdy = rdy; v.clr = clr;
        v.clean = clean; v.rise = rise; v.fall = fall;
        v.valid = valid; v.idx = idx; v.lvl = lvl; v.ovf = ovf;
        return v;
    endfunction

    // Each record: inputs applied at a falling edge, outputs checked at the
    // next falling edge (i.e. after one rising edge has consumed them).
    task automatic run_table(input string tag);
        for (int j = 0; j < tbl.size(); j++) begin
            sw_raw    = tbl[j].raw;
            evt_ready = tbl[j].rdy;
            ovf_clr   = tbl[j].clr;
            @(negedge clk_125);
            $display("%s[%0d] raw=%b rdy=%b clr=%b -> clean=%b rise=%b fall=%b v=%b idx=%0d lvl=%b ovf=%b",
                     tag, j, tbl[j].raw, tbl[j].rdy, tbl[j].clr, sw_clean, sw_rise, sw_fall,
                     evt_valid, evt_idx, evt_level, evt_ovf);
            chk($sformatf("%s[%0d].clean", tag, j), 32'(sw_clean), 32'(tbl[j].clean));
            chk($sformatf("%s[%0d].rise",  tag, j), 32'(sw_rise),  32'(tbl[j].rise));
            chk($sformatf("%s[%0d].fall",  tag, j), 32'(sw_fall),  32'(tbl[j].fall));
            chk($sformatf("%s[%0d].valid", tag, j), 32'(evt_valid), 32'(tbl[j].valid));
            chk($sformatf("%s[%0d].ovf",   tag, j), 32'(evt_ovf),  32'(tbl[j].ovf));
            if (tbl[j].valid) begin
                chk($sformatf("%s[%0d].idx", tag, j), 32'(evt_idx),   32'(tbl[j].idx));
                chk($sformatf("%s[%0d].lvl", tag, j), 32'(evt_level), 32'(tbl[j].lvl));
            end
        end
        tbl.delete();
    endtask

    // Enter and leave on a falling edge; the next rising edge is the first
    // one to sample sw_raw after release.
    task automatic do_reset(input logic [1:0] raw);
        rst_n     = 1'b0;
        sw_raw    = raw;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk_125);
        rst_n = 1'b1;
    endtask

    task automatic chk_evt(input string nm, input logic valid, input logic idx, input logic lvl);
        chk({nm, ".valid"}, 32'(evt_valid), 32'(valid));
        chk({nm, ".idx"},   32'(evt_idx),   32'(idx));
        chk({nm, ".lvl"},   32'(evt_level), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        // ---------------- 1: reset with both switches high
        sw_raw = 2'b11;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk_125);
        chk("t1.rst.clean", 32'(sw_clean), 32'h0);
        chk("t1.rst.rise",  32'(sw_rise),  32'h0);
        chk("t1.rst.fall",  32'(sw_fall),  32'h0);
        chk("t1.rst.ovf",   32'(evt_ovf),  32'h0);
        chk_evt("t1.rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(negedge clk_125);
            chk($sformatf("t1.early%0d.clean", e), 32'(sw_clean), 32'h0);
            chk($sformatf("t1.early%0d.valid", e), 32'(evt_valid), 32'h0);
        end
        @(negedge clk_125);
        $display("t1 edge7 clean=%b rise=%b valid=%b idx=%0d", sw_clean, sw_rise, evt_valid, evt_idx);
        chk("t1.e7.clean", 32'(sw_clean), 32'h3);
        chk("t1.e7.rise",  32'(sw_rise),  32'h3);
        chk_evt("t1.e7", 1'b1, 1'b0, 1'b1);
        @(negedge clk_125);
        chk("t1.e8.rise",  32'(sw_rise),  32'h0);
        chk("t1.e8.clean", 32'(sw_clean), 32'h3);
        evt_ready = 1'b1;
        @(negedge clk_125);
        chk_evt("t1.pop0", 1'b1, 1'b1, 1'b1);
        @(negedge clk_125);
        chk("t1.pop1.valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // ---------------- 2: clean press on ch0, then 3: bounce on ch1
        do_reset(2'b00);
        for (int j = 0; j < 7; j++) tbl.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 2'b01, 2'b01, 2'b00, 1, 0, 1, 0));
        tbl.push_back(mk(2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        run_table("t2");
        for (int j = 0; j < 3; j++) tbl.push_back(mk(2'b11, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        for (int j = 0; j < 9; j++) tbl.push_back(mk(2'b01, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
        run_table("t3");

        // ---------------- 4: overflow (press then release, nobody popping)
        do_reset(2'b00);
        for (int j = 0; j < 7; j++) tbl.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 2'b01, 2'b01, 2'b00, 1, 0, 1, 0));
        for (int j = 0; j < 7; j++) tbl.push_back(mk(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 1));
        tbl.push_back(mk(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
        tbl.push_back(mk(2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        run_table("t4");

        // ---------------- 5: priority and preemption
        do_reset(2'b00);
        sw_raw = 2'b11;
        repeat (7) @(negedge clk_125);
        chk("t5.e6.valid", 32'(evt_valid), 32'h0);
        @(negedge clk_125);
        chk("t5.e7.rise", 32'(sw_rise), 32'h3);
        chk_evt("t5.both", 1'b1, 1'b0, 1'b1);
        evt_ready = 1'b1;
        @(negedge clk_125);
        chk_evt("t5.after_pop0", 1'b1, 1'b1, 1'b1);
        evt_ready = 1'b0;
        sw_raw    = 2'b10;
        for (int e = 0; e < 7; e++) begin
            @(negedge clk_125);
            chk_evt($sformatf("t5.hold%0d", e), 1'b1, 1'b1, 1'b1);
        end
        @(negedge clk_125);
        $display("t5 preempt fall=%b valid=%b idx=%0d lvl=%b", sw_fall, evt_valid, evt_idx, evt_level);
        chk("t5.fall",  32'(sw_fall),  32'h1);
        chk("t5.clean", 32'(sw_clean), 32'h2);
        chk("t5.ovf",   32'(evt_ovf),  32'h0);
        chk_evt("t5.preempt", 1'b1, 1'b0, 1'b0);
        evt_ready = 1'b1;
        @(negedge clk_125);
        chk_evt("t5.back_to_1", 1'b1, 1'b1, 1'b1);
        @(negedge clk_125);
        chk("t5.empty", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // ---------------- 6: reset mid-debounce with ch1 pending
        do_reset(2'b00);
        sw_raw = 2'b10;
        repeat (8) @(negedge clk_125);
        chk_evt("t6.ch1_pend", 1'b1, 1'b1, 1'b1);
        sw_raw = 2'b11;
        repeat (6) @(negedge clk_125);   // ch0 now in WAIT_HI with cnt==2
        rst_n = 1'b0;
        #1;
        $display("t6 async reset clean=%b valid=%b ovf=%b", sw_clean, evt_valid, evt_ovf);
        chk("t6.rst.clean", 32'(sw_clean), 32'h0);
        chk("t6.rst.valid", 32'(evt_valid), 32'h0);
        chk("t6.rst.rise",  32'(sw_rise),  32'h0);
        repeat (2) @(negedge clk_125);
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(negedge clk_125);
            chk($sformatf("t6.wait%0d.clean", e), 32'(sw_clean), 32'h0);
            chk($sformatf("t6.wait%0d.rise",  e), 32'(sw_rise),  32'h0);
            chk($sformatf("t6.wait%0d.valid", e), 32'(evt_valid), 32'h0);
        end
        @(negedge clk_125);
        chk("t6.e7.clean", 32'(sw_clean), 32'h3);
        chk("t6.e7.rise",  32'(sw_rise),  32'h3);
        chk_evt("t6.e7", 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
